multi_clock_divider: RTL and testbench
======================================

# multi_clock_divider

Parametrised N-channel clock divider generating phase-offset divided clocks from the system `clk` for the tag memory (refresh, system and further strobes). Each channel has its own half-period and phase, reprogrammed at runtime through a valid/ready config port. Updates apply glitch-free at that channel's next toggle boundary. A `sync_restart` pulse realigns every channel to its programmed phase.

## Interface
- `CHANNELS`, 2: number of divided-clock channels (1..8).
- `CNT_W`, 9: counter, half-period and phase width.
- `DEF_HALF`, 127: reset half-period; output toggles every `half+1` cycles.
- `INIT_LEVEL`, 1 (CHANNELS bits, bit i = channel i): reset/restart output level. Default is ch0=1, ch1=0.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enabled` in CHANNELS: per-channel run enable.
- `sync_restart` in 1: one-cycle realign strobe.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: config accepted when `cfg_valid && cfg_ready`.
- `cfg_chan` in 3: target channel.
- `cfg_half` in CNT_W: new half-period.
- `cfg_phase` in CNT_W: new phase (counter start value).
- `clk_out` out CHANNELS: divided clocks.
- `edge_pulse` out CHANNELS: one-cycle strobe on the cycle after each `clk_out` toggle.
- `cfg_err` out 1: one-cycle pulse on a rejected config.

## Operation
- Reset values:
  - `half[i]=DEF_HALF`.
  - `phase[i]=i*(DEF_HALF+1)/CHANNELS`, giving 0 and 64 by default.
  - `cnt[i]=phase[i]`.
  - `clk_out=INIT_LEVEL`.
  - `edge_pulse=0`, `cfg_err=0`, `cfg_ready=1`.
  - Pending config cleared.
- Per enabled channel, each cycle:
  - If `cnt<half`: `cnt+1`.
  - Otherwise (`cnt>=half`): toggle `clk_out`, `cnt=0`. This is the toggle event.
- Resulting period is `2*(half+1)` cycles. `half=0` is legal and divides by 2.
- Phase larger than half toggles on the first enabled cycle.
- Disabled channel: `cnt` and `clk_out` frozen; no `edge_pulse`.
- `sync_restart`: every channel gets `cnt=phase`, `clk_out=INIT_LEVEL`, no toggle that cycle. It overrides a same-cycle toggle event.
- Config state machine, two states:
  - **IDLE**: `cfg_ready=1`. Accepting with `cfg_chan<CHANNELS` goes to PEND and latches chan/half/phase. Accepting with `cfg_chan>=CHANNELS` pulses `cfg_err` next cycle and stays IDLE.
  - **PEND**: `cfg_ready=0`. The apply event is the target channel's toggle event, or any cycle in which that channel is disabled. On apply: `half`/`phase` registers are written, `cnt` is zeroed as for a normal toggle (disabled channel: `cnt=new phase`), and the state returns to IDLE.
  - `sync_restart` in PEND applies immediately, and the restart uses the new phase.
- Width: all compares unsigned CNT_W; counters never exceed `max(half,phase)`; no wrap.

## Timing
- `clk_out` is a registered output.
- Toggle occurs at the edge where `cnt==half` is sampled.
- `edge_pulse` is high the cycle after the toggle edge.
- Config accepted at edge t; `cfg_ready` falls after edge t.
- New half governs counting from the cycle after the apply edge.
- `cfg_ready` rises after the apply edge. Minimum accept-to-accept spacing is 2 cycles.
- `reset` asserted mid-operation: all state returns to reset values asynchronously, and any pending config is discarded.
- `enabled` rising: counting resumes from the frozen `cnt` on the same edge.

## Structure
- Package `clk_div_pkg`: `CNT_W_DEF`, `cfg_state_t` enum (`CFG_IDLE`, `CFG_PEND`), and a default-phase function.
- Sub-module `clk_div_channel`:
  - Holds one channel's counter, `half`/`phase` registers, apply port, `edge_pulse` and restart.
  - Instantiated CHANNELS times with a generate loop.
- The top level contains only the config state machine and fan-out.

## Test plan
- Default startup: release `reset`, `enabled=2'b11`.
  - ch1 toggles at edge 64 and ch0 at edge 128.
  - Both then toggle every 128 cycles; ch0 starts at 1, ch1 at 0.
- Reconfigure: write ch0 `half=15`, `phase=0` mid-period.
  - `cfg_ready` stays low until ch0's next toggle.
  - After that, ch0 toggles every 16 cycles with no runt pulse; ch1 is unaffected.
- Disabled apply: with ch1 disabled, write `half=3`, `phase=2`.
  - Applies the next cycle and `cfg_ready` returns after 2 cycles.
  - On enable, ch1 toggles after 2 cycles, then every 4.
- Bad channel: write `cfg_chan=5`.
  - `cfg_err` pulses for 1 cycle; no register changes; `cfg_ready` stays high.
- `sync_restart` mid-run: outputs return to INIT_LEVEL and counters to phase, then the startup toggle pattern repeats. A same-cycle toggle is suppressed.
- Async reset during PEND with `half=0` pending:
  - Outputs are at reset values before the next clock edge.
  - The pending config is lost and divide stays 127.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types, defaults and reset-phase helper for multi_clock_divider.
package clk_div_pkg;

   localparam int CNT_W_DEF = 9;

   typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_t;

   // Spread channels evenly across one half-period at reset.
   function automatic int default_phase(input int idx, input int def_half, input int chans);
      return idx * (def_half + 1) / chans;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divided-clock channel with its counter, half/phase registers,
// glitch-free config apply at its toggle boundary, and restart.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int                CNT_W     = CNT_W_DEF,
   parameter logic [CNT_W-1:0]  RST_HALF  = '0,
   parameter logic [CNT_W-1:0]  RST_PHASE = '0,
   parameter logic              INIT      = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             restart,
   input  logic             apply_req,
   input  logic [CNT_W-1:0] new_half,
   input  logic [CNT_W-1:0] new_phase,
   output logic             clk_out,
   output logic             edge_pulse,
   output logic             applied
);

   logic [CNT_W-1:0] cnt_q, cnt_d, half_q, half_d, phase_q, phase_d;
   logic             out_q, out_d, pulse_q, pulse_d, tog;

   always_comb begin
      tog     = en && (cnt_q >= half_q);
      applied = apply_req && (restart || !en || tog);
      half_d  = applied ? new_half : half_q;
      phase_d = applied ? new_phase : phase_q;
      // Restart wins over a same-cycle toggle and already sees the new phase.
      cnt_d   = restart ? phase_d :
                !en     ? (applied ? new_phase : cnt_q) :
                tog     ? '0 : cnt_q + 1'b1;
      out_d   = restart ? INIT : (tog ? ~out_q : out_q);
      pulse_d = tog && !restart;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= RST_PHASE;
         half_q  <= RST_HALF;
         phase_q <= RST_PHASE;
         out_q   <= INIT;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         phase_q <= phase_d;
         out_q   <= out_d;
         pulse_q <= pulse_d;
      end
   end

   assign clk_out    = out_q;
   assign edge_pulse = pulse_q;

endmodule

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: N phase-offset clock divider channels plus the config
// handshake that holds one pending update until its channel can take it.
module multi_clock_divider
   import clk_div_pkg::*;
#(
   parameter int                   CHANNELS   = 2,
   parameter int                   CNT_W      = CNT_W_DEF,
   parameter int                   DEF_HALF   = 127,
   parameter logic [CHANNELS-1:0]  INIT_LEVEL = CHANNELS'(1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] enabled,
   input  logic                sync_restart,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [2:0]          cfg_chan,
   input  logic [CNT_W-1:0]    cfg_half,
   input  logic [CNT_W-1:0]    cfg_phase,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] edge_pulse,
   output logic                cfg_err
);

   cfg_state_t          state_q, state_d;
   logic [2:0]          chan_q, chan_d;
   logic [CNT_W-1:0]    nhalf_q, nhalf_d, nphase_q, nphase_d;
   logic                err_q, err_d, accept, chan_ok;
   logic [CHANNELS-1:0] apply_req, applied;

   always_comb begin
      cfg_ready = (state_q == CFG_IDLE);
      accept    = cfg_valid && cfg_ready;
      chan_ok   = {29'd0, cfg_chan} < CHANNELS;
      state_d   = state_q;
      chan_d    = chan_q;
      nhalf_d   = nhalf_q;
      nphase_d  = nphase_q;
      err_d     = accept && !chan_ok;
      if (state_q == CFG_IDLE && accept && chan_ok) begin
         state_d  = CFG_PEND;
         chan_d   = cfg_chan;
         nhalf_d  = cfg_half;
         nphase_d = cfg_phase;
      end
      if (state_q == CFG_PEND && |applied)
         state_d = CFG_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= CFG_IDLE;
         chan_q   <= '0;
         nhalf_q  <= '0;
         nphase_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         chan_q   <= chan_d;
         nhalf_q  <= nhalf_d;
         nphase_q <= nphase_d;
         err_q    <= err_d;
      end
   end

   assign cfg_err = err_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      assign apply_req[g] = (state_q == CFG_PEND) && (chan_q == 3'(g));
      clk_div_channel #(
         .CNT_W     (CNT_W),
         .RST_HALF  (CNT_W'(DEF_HALF)),
         .RST_PHASE (CNT_W'(default_phase(g, DEF_HALF, CHANNELS))),
         .INIT      (INIT_LEVEL[g])
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .en         (enabled[g]),
         .restart    (sync_restart),
         .apply_req  (apply_req[g]),
         .new_half   (nhalf_q),
         .new_phase  (nphase_q),
         .clk_out    (clk_out[g]),
         .edge_pulse (edge_pulse[g]),
         .applied    (applied[g])
      );
   end

endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: random and directed stimulus checked every cycle against a
// countdown-to-next-toggle reference model of the divider and its config handshake.
module tb_multi_clock_divider;

   localparam int             CH = 2;
   localparam int             CW = 9;
   localparam int             DH = 127;
   localparam logic [CH-1:0]  IL = 2'b01;

   logic          clk = 1'b0, reset = 1'b0, sync_restart = 1'b0, cfg_valid = 1'b0;
   logic [CH-1:0] enabled = '0;
   logic [2:0]    cfg_chan = '0;
   logic [CW-1:0] cfg_half = '0, cfg_phase = '0;
   logic          cfg_ready, cfg_err;
   logic [CH-1:0] clk_out, edge_pulse;

   multi_clock_divider #(.CHANNELS(CH), .CNT_W(CW), .DEF_HALF(DH), .INIT_LEVEL(IL)) dut (
      .clk          (clk),
      .reset        (reset),
      .enabled      (enabled),
      .sync_restart (sync_restart),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_chan     (cfg_chan),
      .cfg_half     (cfg_half),
      .cfg_phase    (cfg_phase),
      .clk_out      (clk_out),
      .edge_pulse   (edge_pulse),
      .cfg_err      (cfg_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;

   // m_rem: enabled cycles left until the next toggle, the toggle cycle included.
   int m_half[CH], m_phase[CH], m_rem[CH];
   bit m_out[CH], m_pulse[CH];
   bit m_pend, m_err;
   int m_chan, m_nh, m_np;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int start_rem(input int h, input int p);
      return (p >= h) ? 1 : h - p + 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_half[i]  = DH;
         m_phase[i] = i * (DH + 1) / CH;
         m_rem[i]   = start_rem(m_half[i], m_phase[i]);
         m_out[i]   = IL[i];
         m_pulse[i] = 1'b0;
      end
      m_pend = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic model_step();
      bit acc, any_app, tog, app;
      acc     = cfg_valid && !m_pend;
      any_app = 1'b0;
      for (int i = 0; i < CH; i++) begin
         tog = enabled[i] && (m_rem[i] == 1);
         app = m_pend && (m_chan == i) && (sync_restart || !enabled[i] || tog);
         if (app) begin
            m_half[i]  = m_nh;
            m_phase[i] = m_np;
            any_app    = 1'b1;
         end
         m_pulse[i] = 1'b0;
         if (sync_restart) begin
            m_rem[i] = start_rem(m_half[i], m_phase[i]);
            m_out[i] = IL[i];
         end else if (!enabled[i]) begin
            if (app) m_rem[i] = start_rem(m_half[i], m_phase[i]);
         end else if (tog) begin
            m_out[i]   = !m_out[i];
            m_rem[i]   = m_half[i] + 1;
            m_pulse[i] = 1'b1;
         end else begin
            m_rem[i]--;
         end
      end
      m_err = acc && (int'(cfg_chan) >= CH);
      if (m_pend && any_app) m_pend = 1'b0;
      else if (acc && int'(cfg_chan) < CH) begin
         m_pend = 1'b1;
         m_chan = int'(cfg_chan);
         m_nh   = int'(cfg_half);
         m_np   = int'(cfg_phase);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < CH; i++) begin
         chk($sformatf("clk_out%0d", i), 32'(clk_out[i]), 32'(m_out[i]));
         chk($sformatf("edge_pulse%0d", i), 32'(edge_pulse[i]), 32'(m_pulse[i]));
      end
      chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
   endtask

   task automatic drive(input logic [CH-1:0] en, input logic rs, input logic v,
                        input logic [2:0] ch, input logic [CW-1:0] h, input logic [CW-1:0] p);
      enabled      = en;
      sync_restart = rs;
      cfg_valid    = v;
      cfg_chan     = ch;
      cfg_half     = h;
      cfg_phase    = p;
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n, input logic [CH-1:0] en);
      repeat (n) drive(en, 1'b0, 1'b0, 3'd0, '0, '0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_all();
      reset = 1'b1;
      // Default startup: ch1 toggles at edge 64, ch0 at edge 128.
      idle(300, 2'b11);
      // Reconfigure ch0 mid-period to divide by 32.
      drive(2'b11, 1'b0, 1'b1, 3'd0, 9'd15, 9'd0);
      idle(200, 2'b11);
      // Apply to a disabled channel, then enable it.
      drive(2'b01, 1'b0, 1'b1, 3'd1, 9'd3, 9'd2);
      idle(5, 2'b01);
      idle(40, 2'b11);
      // Out-of-range channel.
      drive(2'b11, 1'b0, 1'b1, 3'd5, 9'd7, 9'd7);
      idle(20, 2'b11);
      // Realign mid-run.
      drive(2'b11, 1'b1, 1'b0, 3'd0, '0, '0);
      idle(300, 2'b11);
      repeat (4000) begin
         logic [CH-1:0] en;
         logic [2:0]    ch;
         logic [CW-1:0] h, p;
         en = ($urandom_range(0, 15) == 0) ? CH'($urandom) : 2'b11;
         ch = ($urandom_range(0, 3) == 3) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
         h  = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 511)) : CW'($urandom_range(0, 12));
         p  = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 511)) : CW'($urandom_range(0, 12));
         drive(en, $urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0, ch, h, p);
      end
      // Fresh start, then async reset while a half=0 config is pending.
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(2'b11, 1'b0, 1'b1, 3'd0, 9'd0, 9'd0);
      idle(3, 2'b11);
      cfg_valid = 1'b0;
      #2 reset = 1'b0;
      model_reset();
      #1 check_all();
      #1 reset = 1'b1;
      model_step();
      @(negedge clk);
      check_all();
      idle(300, 2'b11);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
